// File: rtl/pwm_dimmer_pkg.sv
// Shared constants and helpers for the PWM dimmer array.
//   CH_DEF, W_DEF, DEB_CYCLES_DEF : default parameter values
//   sel_width()                   : width of the channel-select port (at least 1)
package pwm_dimmer_pkg;

    localparam int CH_DEF         = 8;
    localparam int W_DEF          = 4;
    localparam int DEB_CYCLES_DEF = 500000;

    function automatic int sel_width(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/pwm_dimmer_array_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debouncer and
// press-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n      : raw active-low button, asynchronous to clk
//   press      : one-cycle pulse when the debounced level goes active
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_END = CW'(DEB_CYCLES - 1);

    // Synchroniser holds the active-high level so reset (all zero) means idle.
    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            deb   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], ~btn_n};
            press <= 1'b0;
            if (sync[1] != deb) begin
                // Level must disagree for DEB_CYCLES cycles in a row; any
                // agreement in between restarts the count.
                if (cnt == CNT_END) begin
                    deb   <= sync[1];
                    cnt   <= '0;
                    press <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_dimmer_array.sv
// Array of CH PWM dimmers sharing one period counter. Two debounced buttons
// step the target of the selected channel; applied duties follow the targets
// only at period boundaries so a running period never glitches.
// Optional build macro: PWM_DIMMER_FADE_EN -- duties step one count per
// period toward the target instead of loading it directly.
//   clk, rst_n         : clock, asynchronous active-low reset
//   btn_up_n, btn_dn_n : raw active-low buttons
//   sel                : channel the buttons act on (>= CH selects none)
//   en                 : per-channel output enable
//   pwm                : per-channel PWM outputs
//   duty_o             : target of channel sel (0 if sel out of range)
//   period_o           : pulse on the last cycle of each period
module pwm_dimmer_array
    import pwm_dimmer_pkg::*;
#(
    parameter int CH         = CH_DEF,
    parameter int W          = W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_up_n,
    input  logic                      btn_dn_n,
    input  logic [sel_width(CH)-1:0]  sel,
    input  logic [CH-1:0]             en,
    output logic [CH-1:0]             pwm,
    output logic [W-1:0]              duty_o,
    output logic                      period_o
);

    // Period is 2^W-1 cycles so duty 2^W-1 can mean "always on".
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0]         cnt;
    logic [CH-1:0][W-1:0] target;
    logic                 up_ev, dn_ev;
    logic                 sel_ok;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_up_n), .press(up_ev)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_dn_n), .press(dn_ev)
    );

    assign sel_ok   = (int'(sel) < CH);
    assign period_o = (cnt == CNT_LAST);
    assign duty_o   = sel_ok ? target[sel] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (period_o) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end

    // Simultaneous up and down cancel; both directions saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (sel_ok && (up_ev ^ dn_ev)) begin
            if (up_ev && (target[sel] != '1))
                target[sel] <= target[sel] + 1'b1;
            else if (dn_ev && (target[sel] != '0))
                target[sel] <= target[sel] - 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] duty;
        logic         pwm_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty  <= '0;
                pwm_r <= 1'b0;
            end else begin
                if (period_o) begin
`ifdef PWM_DIMMER_FADE_EN
                    if (duty < target[i])      duty <= duty + 1'b1;
                    else if (duty > target[i]) duty <= duty - 1'b1;
`else
                    duty <= target[i];
`endif
                end
                pwm_r <= en[i] && (cnt < duty);
            end
        end

        assign pwm[i] = pwm_r;
    end

endmodule

// File: tb/tb_pwm_dimmer_array.sv
module tb_pwm_dimmer_array;

    localparam int CH  = 8;
    localparam int W   = 4;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_up_n = 1'b1;
    logic          btn_dn_n = 1'b1;
    logic [2:0]    sel = '0;
    logic [CH-1:0] en = '1;
    logic [CH-1:0] pwm;
    logic [W-1:0]  duty_o;
    logic          period_o;

    int nvec = 0;
    int nfail = 0;
    int exp_q[$];
    int mt[CH];

    pwm_dimmer_array #(.CH(CH), .W(W), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .sel(sel), .en(en), .pwm(pwm), .duty_o(duty_o), .period_o(period_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press (and release) buttons; the model predicts the new target.
    task automatic press(input bit up, input bit dn);
        @(negedge clk);
        btn_up_n = ~up;
        btn_dn_n = ~dn;
        repeat (12) @(negedge clk);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        repeat (12) @(negedge clk);
        if (up && !dn && mt[sel] < 15) mt[sel]++;
        if (dn && !up && mt[sel] > 0)  mt[sel]--;
        exp_q.push_back(mt[sel]);
        check("duty_o", int'(duty_o), exp_q.pop_front());
    endtask

    task automatic wait_period();
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = period_o;
        end
        check("period_seen", int'(seen), 1);
    endtask

    // Count highs of pwm[ch] over one full period of the applied duty, and
    // OR of every other channel over the same window.
    task automatic measure(input int ch, output int highs, output logic [CH-1:0] others);
        highs  = 0;
        others = '0;
`ifdef PWM_DIMMER_FADE_EN
        repeat (15) wait_period();
`endif
        wait_period();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            if (pwm[ch]) highs++;
            others |= pwm & ~(CH'(1) << ch);
            @(negedge clk);
        end
    endtask

    initial begin
        int highs, n;
        logic [CH-1:0] others;
        foreach (mt[i]) mt[i] = 0;

        // Reset state
        #1;
        check("rst_pwm", int'(pwm), 0);
        check("rst_duty", int'(duty_o), 0);
        check("rst_period", int'(period_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Period length and idle outputs
        wait_period();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_o && n < 40);
        check("period_len", n, 15);
        measure(0, highs, others);
        check("idle_pwm", highs + int'(others), 0);

        // Three clean up presses on channel 2
        sel = 3'd2;
        repeat (3) press(1'b1, 1'b0);
        measure(2, highs, others);
        check("ch2_highs", highs, 3);
        check("ch2_others", int'(others), 0);

        // Enable gates the output only
        en[2] = 1'b0;
        measure(2, highs, others);
        check("ch2_disabled", highs, 0);
        en = '1;

        // Bounced press then long hold: exactly one event
        sel = 3'd3;
        repeat (3) begin
            @(negedge clk) btn_up_n = 1'b0;
            @(negedge clk) btn_up_n = 1'b1;
        end
        @(negedge clk) btn_up_n = 1'b0;
        repeat (10) @(negedge clk);
        mt[3] = 1;
        exp_q.push_back(mt[3]);
        check("bounce_one", int'(duty_o), exp_q.pop_front());
        repeat (100) @(negedge clk);
        exp_q.push_back(mt[3]);
        check("hold_one", int'(duty_o), exp_q.pop_front());
        btn_up_n = 1'b1;
        repeat (12) @(negedge clk);

        // Saturation at the top, full-on output
        sel = 3'd4;
        repeat (16) press(1'b1, 1'b0);
        measure(4, highs, others);
        check("ch4_full", highs, 15);

        // Saturation at zero
        sel = 3'd0;
        press(1'b0, 1'b1);

        // Simultaneous up+down cancels
        sel = 3'd6;
        repeat (7) press(1'b1, 1'b0);
        press(1'b1, 1'b1);

        // Reset mid-period with a held button
        sel = 3'd5;
        repeat (9) press(1'b1, 1'b0);
        @(negedge clk) btn_up_n = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_duty", int'(duty_o), 0);
        check("midrst_period", int'(period_o), 0);
        foreach (mt[i]) mt[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) check("no_early_event", int'(duty_o), 0);
        end while (!period_o && n < 40);
        check("restart_period", n, 14);
        mt[5] = 1;
        exp_q.push_back(mt[5]);
        check("rearm_event", int'(duty_o), exp_q.pop_front());
        btn_up_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/pwm_dimmer_array.md
PWM_DIMMER_ARRAY -- requirements
Module: pwm_dimmer_array

Interface
REQ-001 Parameter CH, default 8: number of independent PWM channels (1..16).
REQ-002 Parameter W, default 4: duty/target register width in bits (2..12).
REQ-003 Parameter DEB_CYCLES, default 500000: required stable-input cycles before a debounced button changes state.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_up_n  input  1  raw push-button, active-low, asynchronous to clk; increments the selected channel.
REQ-007 btn_dn_n  input  1  raw push-button, active-low, asynchronous to clk; decrements the selected channel.
REQ-008 sel  input  $clog2(CH) (min 1)  index of the channel the buttons act on; values >= CH select nothing.
REQ-009 en  input  CH  per-channel enable, active-high; gates pwm output only.
REQ-010 pwm  output  CH  per-channel PWM, active-high.
REQ-011 duty_o  output  W  current target of channel sel; 0 when sel >= CH.
REQ-012 period_o  output  1  one-cycle pulse on the last cycle of each PWM period.

Function
REQ-013 Each button passes a 2-flop synchroniser and then a debouncer; the debounced level toggles only after the synchronised raw level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A press event is the single cycle on which a debounced level goes inactive->active; holding a button produces no further events.
REQ-015 Up event: target[sel] increments by 1, saturating at 2^W-1 (no wrap).
REQ-016 Down event: target[sel] decrements by 1, saturating at 0 (no wrap).
REQ-017 Up and down events on the same cycle: no target change.
REQ-018 A change of sel applies from the next cycle; sel has no effect on duty_o or pwm except through target.
REQ-019 Period counter cnt runs 0..2^W-2 then wraps to 0 (period 2^W-1 cycles); period_o = 1 when cnt = 2^W-2.
REQ-020 Applied duty[i] updates only when period_o = 1 (takes effect at next cnt = 0); no mid-period glitches.
REQ-021 pwm[i] = en[i] AND (cnt < duty[i]), registered (one cycle latency from cnt); duty 0 -> constant low, duty 2^W-1 -> constant high.
REQ-022 duty_o reflects target, updated the cycle after the press event.

Reset
REQ-023 rst_n low: cnt, all target, all duty, synchroniser and debouncer state = 0, debounced levels inactive, pwm = 0, period_o = 0, duty_o = 0.
REQ-024 Reset asserted mid-press or mid-period abandons the operation; after release the period starts at cnt = 0 and a held button must be debounced anew (one event after DEB_CYCLES).

Configuration
REQ-025 Macro PWM_DIMMER_FADE_EN defined: at each period_o, duty[i] moves one step toward target[i] (+1, -1 or hold), giving a linear fade.
REQ-026 Macro PWM_DIMMER_FADE_EN undefined: at each period_o, duty[i] loads target[i] directly; fade logic absent.

Structure
REQ-027 Package pwm_dimmer_pkg holds default parameter constants (CH, W, DEB_CYCLES) and the sel-width computation function.
REQ-028 One sub-module btn_debounce (synchroniser, counter, edge pulse), instantiated twice; PWM channels generated in a loop in the top.

Verification (bench uses DEB_CYCLES = 4, W = 4, CH = 8)
REQ-029 Reset, en = 0xFF, no presses -> pwm = 0x00, duty_o = 0, period_o every 15 cycles.
REQ-030 sel = 2, three clean up presses -> duty_o = 3; from the following period pwm[2] high 3 of 15 cycles, others low.
REQ-031 Up press with 3-cycle bounce pulses then stable 10 cycles -> exactly one event; held 100 cycles -> still one event.
REQ-032 target = 15, up press -> stays 15, pwm[sel] constant high; target = 0, down press -> stays 0; simultaneous up+down at target 7 -> stays 7.
REQ-033 FADE_EN defined, target 0 -> 15 by repeated presses then idle -> duty rises by 1 per period, reaches 15 after 15 periods; undefined -> reaches 15 at the first period boundary after the last press.
REQ-034 rst_n pulsed low mid-period with target[5] = 9 and button held -> all outputs 0 immediately; after release one event only after DEB_CYCLES, duty_o = 1.
